// File: rtl/interrupt_request_resolver.sv
// Purpose: latch IR lines, mask and rotate-resolve priority, own the ISR and EOI/AEOI handling.
// Latency: ir edge -> irr 1 cycle -> int_req 1 more cycle; inta/eoi update state on the next edge.
// Backpressure: none; inta_pulse and eoi_valid are single-cycle strobes and are always accepted.
module interrupt_request_resolver (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ir,
  input  logic       ltim,
  input  logic [7:0] imr,
  input  logic       inta_pulse,
  input  logic       eoi_valid,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  input  logic       rotate,
  input  logic       aeoi,
  output logic       int_req,
  output logic [7:0] irr,
  output logic [7:0] isr,
  output logic [7:0] priority_oh,
  output logic [2:0] vector_idx,
  output logic [2:0] lowest_prio
);

  // Two INTA pulses form one acknowledge sequence; this tracks which one is next.
  typedef enum logic {
    ACK_IDLE  = 1'b0,
    ACK_WAIT2 = 1'b1
  } ack_state_t;

  ack_state_t ack_state;
  ack_state_t ack_state_nxt;

  logic [7:0] ir_q;
  logic [7:0] candidates;

  logic       win_found;
  logic [2:0] win_idx;
  logic       isr_top_found;
  logic [2:0] isr_top_idx;

  logic       first_ack;
  logic       second_ack;

  logic       eoi_clr_vld;
  logic [2:0] eoi_clr_idx;

  logic [7:0] irr_nxt;
  logic [7:0] isr_nxt;
  logic [2:0] vector_idx_nxt;
  logic [2:0] lowest_prio_nxt;
  logic       int_req_nxt;

  assign candidates = irr & ~imr;
  assign first_ack  = inta_pulse && (ack_state == ACK_IDLE);
  assign second_ack = inta_pulse && (ack_state == ACK_WAIT2);

  // Rotating scan from the level just above lowest_prio. The first candidate wins
  // only if no in-service bit is reached first (or on the same level): fully nested rule.
  always_comb begin
    logic       blocked;
    logic [2:0] idx;
    win_found     = 1'b0;
    win_idx       = 3'd0;
    isr_top_found = 1'b0;
    isr_top_idx   = 3'd0;
    blocked       = 1'b0;
    idx           = 3'd0;
    for (int k = 0; k < 8; k++) begin
      idx = lowest_prio + 3'(k + 1);
      if (!isr_top_found && isr[idx]) begin
        isr_top_found = 1'b1;
        isr_top_idx   = idx;
      end
      if (!win_found && !blocked) begin
        if (isr[idx]) begin
          blocked = 1'b1;
        end else if (candidates[idx]) begin
          win_found = 1'b1;
          win_idx   = idx;
        end
      end
    end
  end

  // One-hot grant of the resolved winner, zero when nothing may interrupt.
  always_comb begin
    priority_oh          = 8'h00;
    priority_oh[win_idx] = win_found;
  end

  // EOI decode: which in-service level, if any, this command retires.
  always_comb begin
    eoi_clr_vld = 1'b0;
    eoi_clr_idx = 3'd0;
    if (eoi_valid) begin
      if (eoi_specific) begin
        eoi_clr_idx = eoi_level;
        eoi_clr_vld = isr[eoi_level];
      end else begin
        eoi_clr_idx = isr_top_idx;
        eoi_clr_vld = isr_top_found;
      end
    end
  end

  // Acknowledge sequence next state: each INTA pulse advances modulo 2.
  always_comb begin
    ack_state_nxt = ack_state;
    if (inta_pulse) begin
      case (ack_state)
        ACK_IDLE:  ack_state_nxt = ACK_WAIT2;
        ACK_WAIT2: ack_state_nxt = ACK_IDLE;
        default:   ack_state_nxt = ACK_IDLE;
      endcase
    end
  end

  // Next values of the request/service registers; ack clear overrides a same-cycle edge,
  // EOI works on the pre-cycle ISR so a bit set by this cycle's first INTA survives.
  always_comb begin
    irr_nxt         = ltim ? ir : (irr | (ir & ~ir_q));
    isr_nxt         = isr;
    vector_idx_nxt  = vector_idx;
    lowest_prio_nxt = lowest_prio;

    if (eoi_clr_vld) begin
      isr_nxt[eoi_clr_idx] = 1'b0;
    end

    if (first_ack) begin
      if (win_found) begin
        irr_nxt[win_idx] = 1'b0;
        isr_nxt[win_idx] = 1'b1;
        vector_idx_nxt   = win_idx;
      end else begin
        vector_idx_nxt   = 3'd7;
      end
    end

    if (second_ack && aeoi) begin
      isr_nxt[vector_idx] = 1'b0;
      if (rotate) begin
        lowest_prio_nxt = vector_idx;
      end
    end

    if (rotate && eoi_clr_vld) begin
      lowest_prio_nxt = eoi_clr_idx;
    end

    int_req_nxt = win_found && (ack_state == ACK_IDLE) && !inta_pulse;
  end

  // State registers with synchronous reset; lowest_prio resets to 7 so IR0 is highest.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q        <= 8'h00;
      irr         <= 8'h00;
      isr         <= 8'h00;
      vector_idx  <= 3'd0;
      lowest_prio <= 3'd7;
      int_req     <= 1'b0;
      ack_state   <= ACK_IDLE;
    end else begin
      ir_q        <= ir;
      irr         <= irr_nxt;
      isr         <= isr_nxt;
      vector_idx  <= vector_idx_nxt;
      lowest_prio <= lowest_prio_nxt;
      int_req     <= int_req_nxt;
      ack_state   <= ack_state_nxt;
    end
  end

endmodule
